adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 8-bit ripple adder (the `Adder_8` datapath) among several requesters. Each requester presents operands and a carry-in under a req/gnt handshake. The block registers the winner's operands onto the shared adder, captures sum and carry-out one cycle later, and returns them with the winner's index. It sits between the test/generator modules and the single adder instance.

---
 rtl/adder_arbiter_pkg.sv | 16 +
 rtl/adder_arbiter_rr_pick.sv | 31 +++
 rtl/adder_arbiter.sv | 128 ++++++++++++
 tb/tb_adder_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM encoding, default operand width
// and the pointer-wrap helper.
package adder_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam int ADD_WIDTH = 8;

   function automatic int wrap_inc(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr wins,
// wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [ID_W-1:0]    win_id,
   output logic               any
);

   always_comb begin
      int idx;
      idx    = 0;
      win    = '0;
      win_id = '0;
      any    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any && req[idx]) begin
            win[idx] = 1'b1;
            win_id   = ID_W'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one combinational adder among NUM_REQ requesters:
// grant + operand load in IDLE, result capture in BUSY.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = ADD_WIDTH,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] op_a,
   input  logic [NUM_REQ*WIDTH-1:0] op_b,
   input  logic [NUM_REQ-1:0]       op_cin,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]         add_a,
   output logic [WIDTH-1:0]         add_b,
   output logic                     add_cin,
   input  logic [WIDTH-1:0]         add_sum,
   input  logic                     add_cout,
   output logic [WIDTH-1:0]         res_sum,
   output logic                     res_cout,
   output logic [ID_W-1:0]          res_id,
   output logic                     res_valid
);

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      cur_id_q, cur_id_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [WIDTH-1:0]     add_a_q, add_a_d;
   logic [WIDTH-1:0]     add_b_q, add_b_d;
   logic                 add_cin_q, add_cin_d;
   logic [WIDTH-1:0]     res_sum_q, res_sum_d;
   logic                 res_cout_q, res_cout_d;
   logic [ID_W-1:0]      res_id_q, res_id_d;
   logic                 res_valid_q, res_valid_d;

   logic [NUM_REQ-1:0]   win;
   logic [ID_W-1:0]      win_id;
   logic                 any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .win    (win),
      .win_id (win_id),
      .any    (any)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_id_d    = cur_id_q;
      gnt_d       = '0;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_cin_d   = add_cin_q;
      res_sum_d   = res_sum_q;
      res_cout_d  = res_cout_q;
      res_id_d    = res_id_q;
      res_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any) begin
               add_a_d   = op_a[int'(win_id)*WIDTH +: WIDTH];
               add_b_d   = op_b[int'(win_id)*WIDTH +: WIDTH];
               add_cin_d = op_cin[win_id];
               gnt_d     = win;
               cur_id_d  = win_id;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // The adder has had a full cycle to settle on the registered operands.
            res_sum_d   = add_sum;
            res_cout_d  = add_cout;
            res_id_d    = cur_id_q;
            res_valid_d = 1'b1;
            ptr_d       = ID_W'(wrap_inc(int'(cur_id_q), NUM_REQ));
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cur_id_q    <= '0;
         gnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         res_sum_q   <= '0;
         res_cout_q  <= 1'b0;
         res_id_q    <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_id_q    <= cur_id_d;
         gnt_q       <= gnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cin_q   <= add_cin_d;
         res_sum_q   <= res_sum_d;
         res_cout_q  <= res_cout_d;
         res_id_q    <= res_id_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   assign res_sum   = res_sum_q;
   assign res_cout  = res_cout_q;
   assign res_id    = res_id_q;
   assign res_valid = res_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural 8-bit adder on the add_* port.
module tb_adder_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] op_a;
   logic [NUM_REQ*WIDTH-1:0] op_b;
   logic [NUM_REQ-1:0]       op_cin;
   logic [NUM_REQ-1:0]       gnt;
   logic [WIDTH-1:0]         add_a;
   logic [WIDTH-1:0]         add_b;
   logic                     add_cin;
   logic [WIDTH-1:0]         add_sum;
   logic                     add_cout;
   logic [WIDTH-1:0]         res_sum;
   logic                     res_cout;
   logic [ID_W-1:0]          res_id;
   logic                     res_valid;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

   adder_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_cin    (op_cin),
      .gnt       (gnt),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .res_valid (res_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation from requester id: grant cycle then result cycle.
   task automatic do_op(input int id, input logic [7:0] exp_sum, input logic exp_cout,
                        input logic [NUM_REQ-1:0] req_after);
      step();
      chk("gnt", 32'(gnt), 32'(1 << id));
      chk("rv_in_gnt", 32'(res_valid), 32'd0);
      req = req_after;
      step();
      chk("gnt_in_res", 32'(gnt), 32'd0);
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(id));
      chk("res_sum", 32'(res_sum), 32'(exp_sum));
      chk("res_cout", 32'(res_cout), 32'(exp_cout));
   endtask

   logic [7:0] fa, fb;
   logic [7:0] fib_exp [12] = '{8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55,
                                 8'd89, 8'd144, 8'd233, 8'd121};
   int fair_id [6] = '{0, 1, 2, 3, 0, 1};
   logic [7:0] fair_sum [4] = '{8'd11, 8'd23, 8'd33, 8'd45};

   initial begin
      rst    = 1'b1;
      req    = '0;
      op_a   = '0;
      op_b   = '0;
      op_cin = '0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rv", 32'(res_valid), 32'd0);
      chk("rst_add_a", 32'(add_a), 32'd0);
      chk("rst_add_b", 32'(add_b), 32'd0);
      chk("rst_add_cin", 32'(add_cin), 32'd0);
      chk("rst_sum", 32'(res_sum), 32'd0);
      chk("rst_cout", 32'(res_cout), 32'd0);
      chk("rst_id", 32'(res_id), 32'd0);
      rst = 1'b0;

      // Single request: 3 + 4
      op_a[7:0] = 8'd3;
      op_b[7:0] = 8'd4;
      req = 4'b0001;
      step();
      chk("single_gnt", 32'(gnt), 32'b0001);
      chk("single_add_a", 32'(add_a), 32'd3);
      chk("single_add_b", 32'(add_b), 32'd4);
      req = 4'b0000;
      step();
      chk("single_rv", 32'(res_valid), 32'd1);
      chk("single_sum", 32'(res_sum), 32'd7);
      chk("single_cout", 32'(res_cout), 32'd0);
      chk("single_id", 32'(res_id), 32'd0);
      step();
      chk("single_rv_drop", 32'(res_valid), 32'd0);
      chk("idle_hold_a", 32'(add_a), 32'd3);

      // Overflow on requester 1: FF + 01 + 1
      op_a[15:8] = 8'hFF;
      op_b[15:8] = 8'h01;
      op_cin[1]  = 1'b1;
      req = 4'b0010;
      do_op(1, 8'h01, 1'b1, 4'b0000);

      // Fairness from a fresh pointer, all requesters held high
      rst = 1'b1;
      step();
      rst = 1'b0;
      op_a   = {8'd40, 8'd30, 8'd20, 8'd10};
      op_b   = {8'd4, 8'd3, 8'd2, 8'd1};
      op_cin = 4'b1010;
      req    = 4'b1111;
      for (int i = 0; i < 6; i++)
         do_op(fair_id[i], fair_sum[fair_id[i]], 1'b0, 4'b1111);
      req = 4'b0000;
      step();

      // Pointer wrap: requester 3 wins, then 1001 gives 0 then 3
      req = 4'b1000;
      do_op(3, 8'd45, 1'b0, 4'b0000);
      step();
      req = 4'b1001;
      do_op(0, 8'd11, 1'b0, 4'b1001);
      do_op(3, 8'd45, 1'b0, 4'b0000);
      step();

      // Reset during BUSY discards the result
      req = 4'b0010;
      do_op(1, 8'd23, 1'b0, 4'b0000);
      step();
      req = 4'b0010;
      step();
      chk("mid_gnt", 32'(gnt), 32'b0010);
      req = 4'b0000;
      rst = 1'b1;
      #1;
      chk("mid_async_gnt", 32'(gnt), 32'd0);
      chk("mid_async_add_a", 32'(add_a), 32'd0);
      step();
      chk("mid_rv", 32'(res_valid), 32'd0);
      chk("mid_sum", 32'(res_sum), 32'd0);
      chk("mid_id", 32'(res_id), 32'd0);
      rst = 1'b0;
      req = 4'b0100;
      do_op(2, 8'd33, 1'b0, 4'b0000);
      step();
      req = 4'b0110;
      do_op(1, 8'd23, 1'b0, 4'b0000);
      step();

      // Fibonacci client on requester 0, feeding back res_sum
      op_cin = '0;
      fa = 8'd1;
      fb = 8'd1;
      for (int i = 0; i < 12; i++) begin
         op_a[7:0] = fa;
         op_b[7:0] = fb;
         req = 4'b0001;
         do_op(0, fib_exp[i], (i == 11) ? 1'b1 : 1'b0, 4'b0000);
         fa = fb;
         fb = res_sum;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
